// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Bundles the requester handshakes (instruction refill, load/store) and the
// byte-wide RAM port of the main-memory controller.
//
//   slave  modport : the controller side (mem_ctrl)
//   master modport : the requesters plus the RAM (core / testbench side)
//
// Signals
//   if_valid/if_addr          instruction refill request, word-aligned address
//   if_done/if_data           one-cycle completion pulse and fetched word
//   ic_we/ic_data             icache fill strobe/data (mirror if_done/if_data)
//   ls_valid/ls_wr/ls_len     load/store request, 1 = store, 0/1/2(3) = B/H/W
//   ls_addr/ls_wdata          byte address and store data (low bytes used)
//   ls_done/ls_rdata          one-cycle completion pulse, zero-extended load data
//   mem_din                   RAM read byte, valid one cycle after its address
//   mem_dout/mem_a/mem_wr     RAM write byte, byte address, write strobe
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    logic              ic_we;
    logic [31:0]       ic_data;

    logic              ls_valid;
    logic              ls_wr;
    logic [1:0]        ls_len;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport slave (
        input  if_valid, if_addr,
        input  ls_valid, ls_wr, ls_len, ls_addr, ls_wdata,
        input  mem_din,
        output if_done, if_data, ic_we, ic_data,
        output ls_done, ls_rdata,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_valid, if_addr,
        output ls_valid, ls_wr, ls_len, ls_addr, ls_wdata,
        output mem_din,
        input  if_done, if_data, ic_we, ic_data,
        input  ls_done, ls_rdata,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Byte-wide main-memory controller. Shares one 8-bit RAM port between
// instruction-cache refills (always 4 bytes) and load/store accesses of
// 1, 2 or 4 bytes, sequencing little-endian multi-byte transfers.
//
// Ports
//   clk_in    clock, all state changes on the rising edge
//   rst_n_in  asynchronous active-low reset; drops any in-flight transaction
//   rdy_in    global ready; low freezes every register (edge not counted)
//   flush_in  aborts an instruction fetch / blocks a fetch from starting
//   bus       mem_ctrl_if.slave (requester handshakes + RAM port)
//
// Build option
//   MEM_CTRL_RR_EN  defined   : round-robin arbitration on simultaneous requests
//                   undefined : fixed priority, load/store over instruction
//
// Timing (request accepted at edge E0, length n)
//   read : mem_a = addr+i in the cycle after E0+i, byte i captured at E0+i+2,
//          done in the cycle after E0+n+1
//   write: mem_a/mem_dout/mem_wr for byte i in the cycle after E0+i,
//          done in the cycle after E0+n
// The FSM re-enters IDLE on the edge that raises done, so the done cycle is
// already an idle cycle and the next request is taken on the edge ending it.
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic      clk_in,
    input  logic      rst_n_in,
    input  logic      rdy_in,
    input  logic      flush_in,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;        // edges seen since acceptance
    logic [2:0]        n_q, n_d;            // transaction length in bytes
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;        // read word being assembled

    logic              if_done_q, if_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;

    logic              ls_req, if_req;
    logic              grant_ls, grant_if;
    logic [2:0]        step;                // edge index of the upcoming edge
    logic [2:0]        byte_idx;            // read byte captured at that edge
    logic              last_byte;
    logic [31:0]       merged;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;           // 2 and 3 are both a word
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE)
    // ------------------------------------------------------------------
    assign ls_req = (state_q == IDLE) && bus.ls_valid;
    // A flush at the sampling edge keeps the fetch from starting.
    assign if_req = (state_q == IDLE) && bus.if_valid && !flush_in;

`ifdef MEM_CTRL_RR_EN
    logic last_q, last_d;                   // 1 = instruction won most recently

    // On a tie, grant whichever requester did not win last time.
    assign grant_ls = ls_req && (!if_req || last_q);

    always_comb begin
        last_d = last_q;
        if (grant_ls) begin
            last_d = 1'b0;
        end else if (grant_if) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_q <= 1'b1;                 // so load/store wins the first tie
        end else if (rdy_in) begin
            last_q <= last_d;
        end
    end
`else
    assign grant_ls = ls_req;
`endif

    assign grant_if = if_req && !grant_ls;

    // ------------------------------------------------------------------
    // Byte bookkeeping
    // ------------------------------------------------------------------
    assign step      = cnt_q + 3'd1;
    // Read data lags its address by two edges, so the byte captured at the
    // upcoming edge is the one addressed one edge after acceptance earlier.
    assign byte_idx  = cnt_q - 3'd1;
    assign last_byte = (cnt_q != 3'd0) && (byte_idx == (n_q - 3'd1));

    always_comb begin
        merged = asm_q;
        merged[{byte_idx[1:0], 3'b000} +: 8] = bus.mem_din;
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        if_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;
        // Bus idles at zero whenever no byte is being driven.
        mem_a_d    = '0;
        mem_dout_d = 8'h00;
        mem_wr_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    state_d = bus.ls_wr ? LS_WR : LS_RD;
                    cnt_d   = 3'd0;
                    n_d     = len_to_n(bus.ls_len);
                    addr_d  = bus.ls_addr;
                    wdata_d = bus.ls_wdata;
                    asm_d   = 32'h0;
                    mem_a_d = bus.ls_addr;
                    if (bus.ls_wr) begin
                        mem_dout_d = bus.ls_wdata[7:0];
                        mem_wr_d   = 1'b1;
                    end
                end else if (grant_if) begin
                    state_d = IF_RD;
                    cnt_d   = 3'd0;
                    n_d     = 3'd4;
                    addr_d  = bus.if_addr;
                    asm_d   = 32'h0;
                    mem_a_d = bus.if_addr;
                end
            end

            IF_RD, LS_RD: begin
                cnt_d = step;
                if (step < n_q) begin
                    mem_a_d = addr_q + ADDR_W'(step);
                end
                if (cnt_q != 3'd0) begin
                    asm_d = merged;
                end
                if (last_byte) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == IF_RD) begin
                        if_done_d = 1'b1;
                        if_data_d = merged;
                    end else begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = merged;
                    end
                end
                // Flush abandons a fetch outright, even on its final edge.
                if ((state_q == IF_RD) && flush_in) begin
                    state_d   = IDLE;
                    cnt_d     = 3'd0;
                    asm_d     = asm_q;
                    if_done_d = 1'b0;
                    if_data_d = if_data_q;
                    mem_a_d   = '0;
                end
            end

            LS_WR: begin
                if (step < n_q) begin
                    cnt_d      = step;
                    mem_a_d    = addr_q + ADDR_W'(step);
                    mem_dout_d = wdata_q[{step[1:0], 3'b000} +: 8];
                    mem_wr_d   = 1'b1;
                end else begin
                    state_d   = IDLE;
                    cnt_d     = 3'd0;
                    ls_done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers; rdy_in low holds everything as-is
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            n_q        <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            asm_q      <= 32'h0;
            if_done_q  <= 1'b0;
            if_data_q  <= 32'h0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= 32'h0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h00;
            mem_wr_q   <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ic_we    = if_done_q;
    assign bus.ic_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = mem_wr_q;

endmodule
